// File: rtl/load_store_unit_if.sv
// Request, data-memory and writeback bundle of the load/store unit.
// Also holds the memory alucode encodings shared by the unit and its users.
`ifndef ALU_LB
`define ALU_LB  6'h01
`define ALU_LH  6'h02
`define ALU_LW  6'h03
`define ALU_LBU 6'h04
`define ALU_LHU 6'h05
`define ALU_SB  6'h06
`define ALU_SH  6'h07
`define ALU_SW  6'h08
`endif

interface load_store_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  alucode;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        err;

    modport slave (
        input  in_valid, alucode, addr, store_data, rd_in,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output mem_wstrb, wb_valid, wb_rd, wb_data, err
    );

    modport master (
        output in_valid, alucode, addr, store_data, rd_in,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_wstrb, wb_valid, wb_rd, wb_data, err
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: IDLE -> REQ -> WAIT -> DONE.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic               clk,
    input logic               rst,
    load_store_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    typedef struct packed {
        logic       mem;
        logic       st;
        logic [1:0] size;
        logic       uns;
    } dec_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    function automatic dec_t decode(input logic [5:0] op);
        decode = '0;
        unique case (1'b1)
            (op == `ALU_LB):  decode = '{1'b1, 1'b0, 2'd0, 1'b0};
            (op == `ALU_LH):  decode = '{1'b1, 1'b0, 2'd1, 1'b0};
            (op == `ALU_LW):  decode = '{1'b1, 1'b0, 2'd2, 1'b0};
            (op == `ALU_LBU): decode = '{1'b1, 1'b0, 2'd0, 1'b1};
            (op == `ALU_LHU): decode = '{1'b1, 1'b0, 2'd1, 1'b1};
            (op == `ALU_SB):  decode = '{1'b1, 1'b1, 2'd0, 1'b0};
            (op == `ALU_SH):  decode = '{1'b1, 1'b1, 2'd1, 1'b0};
            (op == `ALU_SW):  decode = '{1'b1, 1'b1, 2'd2, 1'b0};
            default:          decode = '0;
        endcase
    endfunction

    state_t      state, state_n;
    dec_t        in_dec;
    logic        st_q, uns_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, sdata_q;
    logic [31:0] res_q, res_n;
    logic [4:0]  wbrd_q, wbrd_n;
    logic        err_q, err_n;
    logic [7:0]  cnt, cnt_n;
    logic        capture;
    logic        misalign;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ld_data;
    logic [31:0] st_data;
    logic [3:0]  st_strb;

    assign in_dec = decode(bus.alucode);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = in_dec.mem &&
        (((in_dec.size == 2'd1) && bus.addr[0]) ||
         ((in_dec.size == 2'd2) && (bus.addr[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        lane_b = bus.mem_rdata[7:0];
        case (addr_q[1:0])
            2'd0: lane_b = bus.mem_rdata[7:0];
            2'd1: lane_b = bus.mem_rdata[15:8];
            2'd2: lane_b = bus.mem_rdata[23:16];
            2'd3: lane_b = bus.mem_rdata[31:24];
        endcase
        lane_h = addr_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        ld_data = bus.mem_rdata;
        st_data = sdata_q;
        st_strb = 4'b1111;
        case (size_q)
            2'd0: begin
                ld_data = uns_q ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
                st_data = {4{sdata_q[7:0]}};
                st_strb = 4'b0001 << addr_q[1:0];
            end
            2'd1: begin
                ld_data = uns_q ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
                st_data = {2{sdata_q[15:0]}};
                st_strb = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        capture = 1'b0;
        res_n   = res_q;
        wbrd_n  = wbrd_q;
        err_n   = err_q;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_n = DONE;
                    err_n   = 1'b0;
                    res_n   = 32'b0;
                    wbrd_n  = 5'b0;
                    if (!in_dec.mem) begin
                        res_n  = bus.addr;
                        wbrd_n = bus.rd_in;
                    end else if (misalign) begin
                        err_n = 1'b1;
                    end else begin
                        state_n = REQ;
                        capture = 1'b1;
                        cnt_n   = 8'd0;
                        wbrd_n  = in_dec.st ? 5'b0 : bus.rd_in;
                    end
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    cnt_n   = 8'd0;
                    state_n = st_q ? DONE : WAIT;
                end else if (cnt == TO_LAST) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                    wbrd_n  = 5'b0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    res_n   = ld_data;
                    state_n = DONE;
                end else if (cnt == TO_LAST) begin
                    state_n = DONE;
                    err_n   = 1'b1;
                    wbrd_n  = 5'b0;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            st_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'b0;
            sdata_q <= 32'b0;
            res_q   <= 32'b0;
            wbrd_q  <= 5'b0;
            err_q   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            res_q  <= res_n;
            wbrd_q <= wbrd_n;
            err_q  <= err_n;
            if (capture) begin
                st_q    <= in_dec.st;
                uns_q   <= in_dec.uns;
                size_q  <= in_dec.size;
                addr_q  <= bus.addr;
                sdata_q <= bus.store_data;
            end
        end
    end

    // Bus and writeback outputs are held at zero outside their own state.
    assign bus.in_ready  = (state == IDLE);
    assign bus.mem_req   = (state == REQ);
    assign bus.mem_we    = (state == REQ) && st_q;
    assign bus.mem_addr  = (state == REQ) ? {addr_q[31:2], 2'b00} : 32'b0;
    assign bus.mem_wdata = ((state == REQ) && st_q) ? st_data : 32'b0;
    assign bus.mem_wstrb = ((state == REQ) && st_q) ? st_strb : 4'b0;
    assign bus.wb_valid  = (state == DONE);
    assign bus.wb_data   = (state == DONE) ? res_q : 32'b0;
    assign bus.wb_rd     = (state == DONE) ? wbrd_q : 5'b0;
    assign bus.err       = (state == DONE) && err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT=4).
// Honours LSU_MISALIGN_TRAP_EN in the misalign scenario.
`ifndef ALU_LB
`define ALU_LB  6'h01
`define ALU_LH  6'h02
`define ALU_LW  6'h03
`define ALU_LBU 6'h04
`define ALU_LHU 6'h05
`define ALU_SB  6'h06
`define ALU_SH  6'h07
`define ALU_SW  6'h08
`endif

module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // Presents one request for one cycle; returns on the following negedge.
    task automatic drive_req(input logic [5:0] op, input logic [31:0] a,
                             input logic [31:0] sd, input logic [4:0] rd);
        bus.in_valid   = 1'b1;
        bus.alucode    = op;
        bus.addr       = a;
        bus.store_data = sd;
        bus.rd_in      = rd;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
        checks++; if (bus.mem_wstrb !== 4'b0) begin errors++; $display("FAIL rst_wstrb: got %b want 0000", bus.mem_wstrb); end
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %b want 0", bus.wb_valid); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.err); end
        checks++; if (bus.wb_data !== 32'b0) begin errors++; $display("FAIL rst_wb_data: got %h want 0", bus.wb_data); end
        checks++; if (bus.wb_rd !== 5'b0) begin errors++; $display("FAIL rst_wb_rd: got %h want 0", bus.wb_rd); end
        checks++; if (bus.mem_addr !== 32'b0) begin errors++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_byte();
        drive_req(`ALU_SB, 32'h0000_0103, 32'h0000_00AB, 5'd9);
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL sb_req: got %b want 1", bus.mem_req); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL sb_busy: got %b want 0", bus.in_ready); end
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL sb_we: got %b want 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h100) begin errors++; $display("FAIL sb_addr: got %h want 00000100", bus.mem_addr); end
        checks++; if (bus.mem_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b want 1000", bus.mem_wstrb); end
        checks++; if (bus.mem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata: got %h want ababab ab", bus.mem_wdata); end
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL sb_wb_valid: got %b want 1", bus.wb_valid); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL sb_err: got %b want 0", bus.err); end
        checks++; if (bus.wb_rd !== 5'd0 || bus.wb_data !== 32'd0) begin errors++; $display("FAIL sb_wb: got rd %0d data %h want 0 0", bus.wb_rd, bus.wb_data); end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL sb_pulse: got wb_valid %b in_ready %b want 0 1", bus.wb_valid, bus.in_ready); end
    endtask

    task automatic test_store_word();
        drive_req(`ALU_SW, 32'h0000_0300, 32'h1122_3344, 5'd3);
        checks++; if (bus.mem_wstrb !== 4'b1111) begin errors++; $display("FAIL sw_wstrb: got %b want 1111", bus.mem_wstrb); end
        checks++; if (bus.mem_wdata !== 32'h1122_3344) begin errors++; $display("FAIL sw_wdata: got %h want 11223344", bus.mem_wdata); end
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL sw_wb_valid: got %b want 1", bus.wb_valid); end
        @(negedge clk);
    endtask

    task automatic test_load_byte();
        logic [5:0]  ops [2] = '{`ALU_LB, `ALU_LBU};
        logic [31:0] exp [2] = '{32'hFFFF_FF80, 32'h0000_0080};
        for (int i = 0; i < 2; i++) begin
            drive_req(ops[i], 32'h0000_0102, 32'h0, 5'd12);
            checks++; if (bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0) begin errors++; $display("FAIL lb_req[%0d]: got addr %h we %b want 00000100 0", i, bus.mem_addr, bus.mem_we); end
            bus.mem_gnt = 1'b1;
            // a stray response while still in REQ must not be taken
            bus.mem_rvalid = (i == 1);
            bus.mem_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL lb_wait[%0d]: got wb_valid %b want 0", i, bus.wb_valid); end
            @(negedge clk);
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = 32'h0080_0000;
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            checks++; if (bus.wb_valid !== 1'b1 || bus.err !== 1'b0) begin errors++; $display("FAIL lb_done[%0d]: got wb_valid %b err %b want 1 0", i, bus.wb_valid, bus.err); end
            checks++; if (bus.wb_data !== exp[i]) begin errors++; $display("FAIL lb_data[%0d]: got %h want %h", i, bus.wb_data, exp[i]); end
            checks++; if (bus.wb_rd !== 5'd12) begin errors++; $display("FAIL lb_rd[%0d]: got %0d want 12", i, bus.wb_rd); end
            @(negedge clk);
        end
    endtask

    task automatic test_halfword();
        logic [5:0]  ops [2] = '{`ALU_LHU, `ALU_LH};
        logic [31:0] ad  [2] = '{32'h0000_0202, 32'h0000_0200};
        logic [31:0] rd  [2] = '{32'hBEEF_1234, 32'h0000_8001};
        logic [31:0] exp [2] = '{32'h0000_BEEF, 32'hFFFF_8001};
        for (int i = 0; i < 2; i++) begin
            drive_req(ops[i], ad[i], 32'h0, 5'd4);
            bus.mem_gnt = 1'b1;
            @(negedge clk);
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rd[i];
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== exp[i]) begin errors++; $display("FAIL lh_data[%0d]: got valid %b data %h want 1 %h", i, bus.wb_valid, bus.wb_data, exp[i]); end
            @(negedge clk);
        end
        drive_req(`ALU_SH, 32'h0000_0202, 32'h0000_5678, 5'd4);
        checks++; if (bus.mem_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b want 1100", bus.mem_wstrb); end
        checks++; if (bus.mem_wdata !== 32'h5678_5678) begin errors++; $display("FAIL sh_wdata: got %h want 56785678", bus.mem_wdata); end
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n = 0;
        int guard = 0;
        drive_req(`ALU_LW, 32'h0000_0400, 32'h0, 5'd7);
        while (bus.wb_valid !== 1'b1 && guard < 20) begin
            if (bus.mem_req === 1'b1) n++;
            @(negedge clk);
            guard++;
        end
        checks++; if (guard >= 20) begin errors++; $display("FAIL to_bound: got no wb_valid in %0d cycles want <20", guard); end
        checks++; if (n != 4) begin errors++; $display("FAIL to_req_cycles: got %0d want 4", n); end
        checks++; if (bus.mem_req !== 1'b0 || bus.err !== 1'b1) begin errors++; $display("FAIL to_err: got req %b err %b want 0 1", bus.mem_req, bus.err); end
        checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL to_rd: got %0d want 0", bus.wb_rd); end
        @(negedge clk);
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL to_err_clear: got %b want 0", bus.err); end
    endtask

    task automatic test_misalign();
        drive_req(`ALU_LW, 32'h0000_0101, 32'h0, 5'd6);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mis_req: got %b want 0", bus.mem_req); end
        checks++; if (bus.wb_valid !== 1'b1 || bus.err !== 1'b1 || bus.wb_rd !== 5'd0) begin errors++; $display("FAIL mis_trap: got valid %b err %b rd %0d want 1 1 0", bus.wb_valid, bus.err, bus.wb_rd); end
        @(negedge clk);
`else
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin errors++; $display("FAIL mis_req: got req %b addr %h want 1 00000100", bus.mem_req, bus.mem_addr); end
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_BABE;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.wb_valid !== 1'b1 || bus.err !== 1'b0 || bus.wb_data !== 32'hCAFE_BABE) begin errors++; $display("FAIL mis_load: got valid %b err %b data %h want 1 0 cafebabe", bus.wb_valid, bus.err, bus.wb_data); end
        @(negedge clk);
`endif
    endtask

    task automatic test_passthrough();
        drive_req(6'h3F, 32'h1234_5678, 32'h0, 5'd7);
        checks++; if (bus.wb_valid !== 1'b1 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL pt_valid: got valid %b req %b want 1 0", bus.wb_valid, bus.mem_req); end
        checks++; if (bus.wb_data !== 32'h1234_5678 || bus.wb_rd !== 5'd7) begin errors++; $display("FAIL pt_data: got %h rd %0d want 12345678 7", bus.wb_data, bus.wb_rd); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_req(`ALU_LB, 32'h0000_0102, 32'h0, 5'd15);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h0080_0000;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rm_wb_valid: got %b want 0", bus.wb_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.wb_valid !== 1'b0 || bus.mem_req !== 1'b0) begin errors++; $display("FAIL rm_idle: got valid %b req %b want 0 0", bus.wb_valid, bus.mem_req); end
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.alucode    = 6'h0;
        bus.addr       = 32'h0;
        bus.store_data = 32'h0;
        bus.rd_in      = 5'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
        test_reset();
        test_store_byte();
        test_store_word();
        test_load_byte();
        test_halfword();
        test_timeout();
        test_misalign();
        test_passthrough();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting in REQ or WAIT before abort; legal range 1..255.
REQ-002 SHALL have ports clk (in, 1, single clock) and rst (in, 1, reset): one clock; reset is synchronous and active-high.
REQ-003 in_valid (in, 1): a memory-op request is presented.
REQ-004 in_ready (out, 1): unit accepts a request this cycle.
REQ-005 alucode (in, 6): op select, one of `ALU_LB/LH/LW/LBU/LHU/SB/SH/SW`; any other code is a pass-through.
REQ-006 addr (in, 32): effective address, taken from the ALU result.
REQ-007 store_data (in, 32): rs2 value for stores.
REQ-008 rd_in (in, 5): destination register.
REQ-009 mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32, word-aligned), mem_wdata (out, 32), mem_wstrb (out, 4): data-memory request.
REQ-010 mem_gnt (in, 1): request accepted; mem_rvalid (in, 1) and mem_rdata (in, 32): load response.
REQ-011 wb_valid (out, 1), wb_rd (out, 5), wb_data (out, 32): writeback result; err (out, 1): access fault.

Function
REQ-012 SHALL use FSM states IDLE, REQ, WAIT and DONE; in_ready SHALL be 1 only in IDLE.
REQ-013 In IDLE, in_valid=1 with a memory alucode SHALL register alucode, addr, store_data and rd_in, then go to REQ; a non-memory alucode SHALL go directly to DONE with wb_data=addr.
REQ-014 In REQ, mem_req SHALL be 1 with stable outputs; mem_addr SHALL be {addr[31:2],2'b00}.
REQ-015 On mem_gnt in REQ, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-016 In WAIT, mem_rvalid SHALL capture the extracted load data and go to DONE; mem_rvalid outside WAIT SHALL be ignored.
REQ-017 In DONE, wb_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; back-to-back requests therefore have at least one idle cycle between them.
REQ-018 Byte lane: SB SHALL drive wstrb=4'b0001<<addr[1:0] and replicate store_data[7:0] into all four bytes.
REQ-019 Halfword lane: SH SHALL drive wstrb=4'b0011<<{addr[1],1'b0} and replicate store_data[15:0]; SW SHALL drive wstrb=4'b1111.
REQ-020 Load extract: LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; lanes are selected by addr[1:0] (halfword by addr[1]).
REQ-021 For stores, wb_data SHALL be 0 and wb_rd SHALL be 0.
REQ-022 A wait counter SHALL clear on entry to REQ and on mem_gnt; on reaching TIMEOUT in REQ or WAIT, the unit SHALL drop mem_req, go to DONE, and set err=1 with wb_rd=0.
REQ-023 err SHALL be valid only while wb_valid=1 and SHALL otherwise be 0.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE and clear the counter, even mid-transaction; any in-flight memory response SHALL be discarded.
REQ-025 After reset, outputs SHALL be: in_ready=1, mem_req=0, mem_we=0, mem_wstrb=0, wb_valid=0, err=0, wb_data=0, wb_rd=0, mem_addr=0.

Configuration
REQ-026 With macro LSU_MISALIGN_TRAP_EN defined, LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, SHALL issue no memory request and SHALL go to DONE with err=1 and wb_rd=0.
REQ-027 Without LSU_MISALIGN_TRAP_EN, misaligned low address bits SHALL be ignored: halfword uses addr[1] and word uses lane 0, and no error is raised.

Verification
REQ-028 Store test: SB with addr=0x103 and store_data=0xAB -> mem_addr=0x100, wstrb=4'b1000, wdata=0xABABABAB, and wb_valid pulses with err=0.
REQ-029 Load test: LB with addr=0x102, mem_rdata=0x00800000 returned 2 cycles after gnt -> wb_data=0xFFFFFF80; the same access as LBU -> wb_data=0x00000080.
REQ-030 Halfword test: LHU with addr=0x202 and rdata=0xBEEF1234 -> wb_data=0x0000BEEF; SH with addr=0x202 -> wstrb=4'b1100.
REQ-031 Timeout test: with TIMEOUT=4, mem_gnt held at 0 -> mem_req drops after 4 cycles, wb_valid=1, err=1, wb_rd=0.
REQ-032 Misalign test: LW with addr=0x101 -> with LSU_MISALIGN_TRAP_EN, no mem_req and err=1; without it, mem_addr=0x100 and err=0.
REQ-033 Reset test: assert rst in WAIT, then a late mem_rvalid arrives -> in IDLE, wb_valid stays 0, in_ready=1.
